// File: rtl/sdrd_deserializer.sv
// SDRD readback deserializer: assembles qualified serial bits LSB-first into
// words and queues them in a small registered-head FIFO for the host bus.
module sdrd_deserializer #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sdrd,
  input  logic                          bit_stb,
  input  logic                          seq_abort,
  input  logic                          rd_stb,
  output logic [WORD_W-1:0]             rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORD_W);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ASM  = 1'b1;

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] asm_word;
  logic [15:0]       timer;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic              in_asm;
  logic              accept;
  logic              drop_abort;
  logic              drop_tmo;
  logic              word_done;
  logic              do_pop;
  logic              do_push;
  logic              at_cap;
  logic              ovf_evt;
  logic [LW-1:0]     remain;
  logic [LW-1:0]     level_nxt;
  logic [AW-1:0]     head_idx;
  logic [WORD_W-1:0] head_nxt;

  // Abort beats a coincident strobe; a strobe beats a coincident timeout.
  always_comb begin
    in_asm     = (state == ST_ASM);
    accept     = bit_stb & ~seq_abort;
    drop_abort = in_asm & seq_abort;
    drop_tmo   = in_asm & ~bit_stb & ~seq_abort & (timer == 16'(TIMEOUT - 1));
    word_done  = accept & (cnt == CW'(WORD_W - 1));
  end

  // shreg is all-zero in IDLE, so the same insert path serves the first bit.
  always_comb begin
    asm_word = shreg;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (CW'(i) == cnt) asm_word[i] = sdrd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      timer <= '0;
    end else if (drop_abort || drop_tmo) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      timer <= '0;
    end else if (accept) begin
      timer <= '0;
      if (word_done) begin
        state <= ST_IDLE;
        cnt   <= '0;
        shreg <= '0;
      end else begin
        state <= ST_ASM;
        cnt   <= cnt + 1'b1;
        shreg <= asm_word;
      end
    end else if (in_asm) begin
      timer <= timer + 1'b1;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  always_comb begin
    do_pop    = rd_stb & (level != '0);
    at_cap    = (level == LW'(FIFO_DEPTH));
    do_push   = word_done & (~at_cap | do_pop);
    ovf_evt   = word_done & at_cap & ~do_pop;
    remain    = level - LW'(do_pop);
    level_nxt = remain + LW'(do_push);
    head_idx  = rd_ptr + AW'(do_pop);
    head_nxt  = '0;
    if (remain == '0) begin
      if (do_push) head_nxt = asm_word;
    end else begin
      head_nxt = mem[head_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= asm_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level   <= level_nxt;
      empty   <= (level_nxt == '0);
      full    <= (level_nxt == LW'(FIFO_DEPTH));
      rd_data <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_evt)                    overflow  <= 1'b1;
      else if (clr_err)               overflow  <= 1'b0;
      if (drop_abort || drop_tmo)     frame_err <= 1'b1;
      else if (clr_err)               frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Directed bench for sdrd_deserializer with a queue scoreboard of expected words.
module tb_sdrd_deserializer;

  logic       clk = 1'b0;
  logic       rst_n, sdrd, bit_stb, seq_abort, rd_stb, clr_err;
  logic [7:0] rd_data;
  logic       empty, full, overflow, frame_err;
  logic [2:0] level;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  sdrd_deserializer #(.WORD_W(8), .FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .sdrd(sdrd), .bit_stb(bit_stb),
    .seq_abort(seq_abort), .rd_stb(rd_stb), .rd_data(rd_data),
    .empty(empty), .full(full), .level(level), .overflow(overflow),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bit_stb = 1'b1; sdrd = b;
    tick();
    bit_stb = 1'b0; sdrd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_word(input logic [7:0] w);
    if (sb.size() < 4) sb.push_back(w);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    expect_word(w);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (sb.size() != 0) ? sb[0] : 8'h00;
    chk(tag, 16'(rd_data), 16'(e));
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_data"}, 16'(rd_data), 16'h0);
    chk({tag, "_empty"}, 16'(empty), 16'h1);
    chk({tag, "_full"}, 16'(full), 16'h0);
    chk({tag, "_level"}, 16'(level), 16'h0);
    chk({tag, "_ovf"}, 16'(overflow), 16'h0);
    chk({tag, "_ferr"}, 16'(frame_err), 16'h0);
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b0; sdrd = 1'b0; bit_stb = 1'b0; seq_abort = 1'b0;
    rd_stb = 1'b0; clr_err = 1'b0;
    idle(2);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // 0xA5 sent LSB-first as 1,0,1,0,0,1,0,1
    send_word(8'hA5);
    chk("a5_level", 16'(level), 16'h1);
    chk("a5_empty", 16'(empty), 16'h0);
    pop_check("a5_pop");
    chk("a5_empty_after", 16'(empty), 16'h1);
    chk("a5_rd_after", 16'(rd_data), 16'h0);

    // five words into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_word(8'(i));
    chk("ovf_full", 16'(full), 16'h1);
    chk("ovf_level", 16'(level), 16'h4);
    chk("ovf_flag", 16'(overflow), 16'h1);
    for (int i = 0; i < 4; i++) pop_check("ovf_pop");
    chk("ovf_empty", 16'(empty), 16'h1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovf_clr", 16'(overflow), 16'h0);

    // timeout after 255 idle cycles
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    idle(254);
    chk("tmo_254", 16'(frame_err), 16'h0);
    idle(1);
    chk("tmo_ferr", 16'(frame_err), 16'h1);
    chk("tmo_level", 16'(level), 16'h0);
    send_word(8'hFF);
    chk("tmo_ff_level", 16'(level), 16'h1);
    pop_check("tmo_ff_pop");
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("tmo_clr", 16'(frame_err), 16'h0);

    // bit arriving on gap cycle 255 is accepted
    w = 8'h5A;
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    idle(254);
    for (int i = 3; i < 8; i++) send_bit(w[i]);
    expect_word(w);
    chk("edge_ferr", 16'(frame_err), 16'h0);
    chk("edge_level", 16'(level), 16'h1);
    pop_check("edge_pop");

    // abort with a coincident strobe
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    seq_abort = 1'b1; bit_stb = 1'b1; sdrd = 1'b1;
    tick();
    seq_abort = 1'b0; bit_stb = 1'b0; sdrd = 1'b0;
    chk("abt_ferr", 16'(frame_err), 16'h1);
    chk("abt_empty", 16'(empty), 16'h1);
    idle(2);
    chk("abt_level", 16'(level), 16'h0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("abt_clr", 16'(frame_err), 16'h0);
    send_bit(1'b1); send_bit(1'b0);
    seq_abort = 1'b1; clr_err = 1'b1;
    tick();
    seq_abort = 1'b0; clr_err = 1'b0;
    chk("abt_clr_race", 16'(frame_err), 16'h1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("abt_clr2", 16'(frame_err), 16'h0);
    send_word(8'h3C);
    pop_check("abt_clean_pop");

    // full FIFO, word completes while the host pops
    for (int i = 0; i < 4; i++) send_word(8'h11 + 8'(i));
    chk("pp_full", 16'(full), 16'h1);
    w = 8'h15;
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    chk("pp_head", 16'(rd_data), 16'(sb[0]));
    bit_stb = 1'b1; sdrd = w[7]; rd_stb = 1'b1;
    tick();
    bit_stb = 1'b0; sdrd = 1'b0; rd_stb = 1'b0;
    void'(sb.pop_front());
    expect_word(w);
    chk("pp_ovf", 16'(overflow), 16'h0);
    chk("pp_level", 16'(level), 16'h4);
    chk("pp_full2", 16'(full), 16'h1);
    for (int i = 0; i < 4; i++) pop_check("pp_pop");
    chk("pp_empty", 16'(empty), 16'h1);

    // asynchronous reset mid-word with two words queued
    send_word(8'h21);
    send_word(8'h22);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk("ar_level_pre", 16'(level), 16'h2);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("arst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_word(8'h96);
    chk("ar_level", 16'(level), 16'h1);
    pop_check("ar_pop");
    chk("ar_empty", 16'(empty), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdrd_deserializer.md
Name: sdrd_deserializer

Overview:
- Downstream consumer of the serial-readback sequencer's SDRD bit output.
- Samples each qualified SDRD bit, assembles bits LSB-first into WORD_W-bit words, and buffers completed words in a small FIFO for the host bus.
- Provides an inter-bit timeout to discard stalled partial words, a sticky overflow flag and a sticky framing-error flag for the host.

Parameters:
WORD_W, 8, bits per assembled word (2..16)
FIFO_DEPTH, 4, words of buffering (power of two, 2..16)
TIMEOUT, 255, max idle clk cycles between bits of one word before the partial word is discarded (1..65535)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
sdrd  in  1  serial data bit from the sequencer; value is don't-care unless bit_stb is high
bit_stb  in  1  one-cycle strobe; sdrd is valid in this cycle (qualified externally by ~SSER & ~BA13 & BA12 & BR_W)
seq_abort  in  1  sequencer left the readback window; discard the partial word
rd_stb  in  1  host read pop, one cycle
rd_data  out  WORD_W  FIFO head word, valid when empty=0
empty  out  1  FIFO holds no words
full  out  1  FIFO holds FIFO_DEPTH words
level  out  clog2(FIFO_DEPTH)+1  number of words held
overflow  out  1  sticky: a word completed while the FIFO was full
frame_err  out  1  sticky: a partial word was discarded by timeout or seq_abort
clr_err  in  1  clears overflow and frame_err

Behaviour:
- Reset (async assert, sync release), all outputs: rd_data=0, empty=1, full=0, level=0, overflow=0, frame_err=0. The shift register, bit count and timeout counter also clear, and the FSM enters IDLE.
- FSM states:
  - IDLE: bit count = 0, timer stopped.
  - ASSEMBLE: 1 to WORD_W-1 bits held.
- IDLE transitions:
  - bit_stb shifts sdrd into bit 0 and sets count = 1.
  - Go to ASSEMBLE, or push the word immediately when WORD_W==1 (forbidden by the parameter range).
- ASSEMBLE, each bit_stb:
  - sdrd is placed at position count (LSB-first); count increments; the timer reloads to 0.
  - When count reaches WORD_W, the word is pushed the same cycle, count returns to 0, and the FSM goes to IDLE.
  - The pushed word becomes visible at rd_data/level on the next cycle (1-cycle latency).
- ASSEMBLE timer:
  - Increments each cycle without bit_stb.
  - When it reaches TIMEOUT, the partial word is dropped, frame_err is set and the FSM goes to IDLE.
  - A bit_stb in the same cycle the timer hits TIMEOUT is accepted; the timeout does not fire.
- seq_abort:
  - In ASSEMBLE: drops the partial word, sets frame_err and goes to IDLE.
  - In IDLE: no effect.
  - If seq_abort and bit_stb occur together, abort wins and the bit is discarded.
- Push with FIFO full: the word is discarded, overflow is set, and FIFO contents are unchanged.
- Push and rd_stb in the same cycle:
  - FIFO not empty: both occur and level is unchanged. If the FIFO was full, this is not an overflow (the pop frees the slot).
  - FIFO empty: the push occurs and the pop is ignored.
- rd_stb while empty: ignored; no state change and no error.
- rd_data is the registered FIFO head. It is 0 when empty, and shows the next word the cycle after a pop.
- Pointers wrap modulo FIFO_DEPTH. full = (level==FIFO_DEPTH) and empty = (level==0), both registered.
- clr_err: clears both sticky flags. A set event in the same cycle wins (flag stays 1).
- Reset mid-word or with a non-empty FIFO discards everything; no flag is set by reset.

Test Plan:
- Reset, then 8 bit_stb with sdrd pattern 1,0,1,0,0,1,0,1 (one bit per cycle) -> after 1 cycle rd_data=0xA5, level=1, empty=0; after rd_stb -> empty=1, rd_data=0.
- Push 5 words 0x01..0x05 with no reads (FIFO_DEPTH=4) -> full=1, level=4, overflow=1; popping 4 times yields 0x01,0x02,0x03,0x04, then empty=1.
- 3 bits, then no strobe for 255 cycles -> frame_err=1, level=0. The next 8 bits give a clean word 0xFF. A bit arriving on exactly cycle 255 of the gap is accepted.
- seq_abort after 5 bits, with bit_stb asserted in the same cycle -> frame_err=1, no word pushed. clr_err -> frame_err=0. Also drive clr_err together with a new abort -> frame_err stays 1.
- FIFO full plus a word completing in the same cycle as rd_stb -> overflow stays 0, level stays 4, and the popped and pushed words are ordered correctly.
- Assert rst_n low asynchronously mid-word with 2 words queued -> all outputs go to their reset values immediately, without waiting for a clk edge; after release, 8 new bits produce a word with no residue from the old partial word.
